pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the IF/ID register controls (enableIF, resetIF), the PC write enable, the PC source select and the ID/EX bubble insert.
- Detects load-use hazards, flushes on taken branches (resolved in EX) and jumps (resolved in ID), and freezes the whole pipe while data memory is busy.
- Holds the pipe idle for a fixed number of cycles after reset and keeps saturating stall/flush event counters.

---
 rtl/pipe_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: reset hold, memory freeze,
// branch/jump flush and load-use stall, plus saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned RESET_HOLD = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             reloj,
    input  logic             resetn,
    input  logic [5:0]       opcode_id,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken_ex,
    input  logic             dmem_busy,
    output logic             pc_enable,
    output logic [1:0]       pc_sel,
    output logic             enableIF,
    output logic             resetIF,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned HOLD_W = 4;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold;
    logic              stall_ev, flush_ev;
    logic              jump_id, reads_rt, load_use;

    // Only these opcodes actually read rt as a source operand.
    assign jump_id  = (opcode_id == OP_J) || (opcode_id == OP_JAL);
    assign reads_rt = (opcode_id == OP_RTYPE) || (opcode_id == OP_BEQ) ||
                      (opcode_id == OP_BNE)   || (opcode_id == OP_SW);
    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == rs_id) || ((idex_rt == rt_id) && reads_rt));

    always_comb begin
        state_nxt   = state;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        pc_enable   = 1'b0;
        pc_sel      = SEL_PC4;
        enableIF    = 1'b0;
        resetIF     = 1'b1;
        idex_bubble = 1'b1;
        case (state)
            INIT: begin
                if (hold == HOLD_LAST) state_nxt = RUN;
            end
            default: begin
                resetIF     = 1'b0;
                idex_bubble = 1'b0;
                if (dmem_busy) begin
                    state_nxt = FREEZE;
                end else begin
                    // Leaving FREEZE evaluates the normal rules in the same cycle.
                    state_nxt = RUN;
                    if (branch_taken_ex) begin
                        pc_enable   = 1'b1;
                        pc_sel      = SEL_BRANCH;
                        resetIF     = 1'b1;
                        idex_bubble = 1'b1;
                        flush_ev    = 1'b1;
                    end else if (jump_id) begin
                        pc_enable = 1'b1;
                        pc_sel    = SEL_JUMP;
                        resetIF   = 1'b1;
                        flush_ev  = 1'b1;
                    end else if (load_use) begin
                        idex_bubble = 1'b1;
                        stall_ev    = 1'b1;
                    end else begin
                        pc_enable = 1'b1;
                        enableIF  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge reloj or negedge resetn) begin
        if (!resetn) begin
            state     <= INIT;
            hold      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) hold <= hold + HOLD_W'(1);
            if (stall_ev && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_ev && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// against a rule-level model, on a 16-bit and a 4-bit counter instance.
module tb_pipe_hazard_ctrl;

    localparam int RH = 2;

    logic       reloj = 1'b0;
    logic       resetn;
    logic [5:0] opcode_id;
    logic [4:0] rs_id, rt_id, idex_rt;
    logic       idex_memread, branch_taken_ex, dmem_busy;

    logic        pc_enable, enableIF, resetIF, idex_bubble;
    logic [1:0]  pc_sel;
    logic [15:0] stall16, flush16;
    logic        pc_enable4, enableIF4, resetIF4, idex_bubble4;
    logic [1:0]  pc_sel4;
    logic [3:0]  stall4, flush4;

    int pass_cnt = 0;
    int total    = 0;

    int cyc  = 0;
    int sc16 = 0, fc16 = 0, sc4 = 0, fc4 = 0;

    pipe_hazard_ctrl #(.RESET_HOLD(RH), .CNT_W(16)) dut16 (
        .reloj(reloj), .resetn(resetn), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .branch_taken_ex(branch_taken_ex),
        .dmem_busy(dmem_busy), .pc_enable(pc_enable), .pc_sel(pc_sel), .enableIF(enableIF),
        .resetIF(resetIF), .idex_bubble(idex_bubble), .stall_cnt(stall16), .flush_cnt(flush16)
    );

    pipe_hazard_ctrl #(.RESET_HOLD(RH), .CNT_W(4)) dut4 (
        .reloj(reloj), .resetn(resetn), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .branch_taken_ex(branch_taken_ex),
        .dmem_busy(dmem_busy), .pc_enable(pc_enable4), .pc_sel(pc_sel4), .enableIF(enableIF4),
        .resetIF(resetIF4), .idex_bubble(idex_bubble4), .stall_cnt(stall4), .flush_cnt(flush4)
    );

    always #5 reloj = ~reloj;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected {pc_enable, pc_sel, enableIF, resetIF, idex_bubble} and event flags.
    function automatic void model(input int c, output logic [5:0] o, output logic st,
                                  output logic fl);
        logic lu;
        lu = idex_memread && (idex_rt != 0) &&
             (idex_rt == rs_id || (idex_rt == rt_id &&
              (opcode_id == 6'h00 || opcode_id == 6'h04 || opcode_id == 6'h05 ||
               opcode_id == 6'h2b)));
        st = 1'b0;
        fl = 1'b0;
        if (c < RH)                                  o = 6'b0_00_011;
        else if (dmem_busy)                          o = 6'b0_00_000;
        else if (branch_taken_ex) begin              o = 6'b1_01_011; fl = 1'b1; end
        else if (opcode_id == 6'h02 || opcode_id == 6'h03) begin
                                                     o = 6'b1_10_010; fl = 1'b1; end
        else if (lu) begin                           o = 6'b0_00_001; st = 1'b1; end
        else                                         o = 6'b1_00_100;
    endfunction

    logic [5:0] upd_o;
    logic       upd_st, upd_fl;
    always @(posedge reloj or negedge resetn) begin
        if (!resetn) begin
            cyc <= 0; sc16 <= 0; fc16 <= 0; sc4 <= 0; fc4 <= 0;
        end else begin
            model(cyc, upd_o, upd_st, upd_fl);
            if (cyc < RH) cyc <= cyc + 1;
            if (upd_st) begin
                sc16 <= (sc16 < 65535) ? sc16 + 1 : sc16;
                sc4  <= (sc4 < 15) ? sc4 + 1 : sc4;
            end
            if (upd_fl) begin
                fc16 <= (fc16 < 65535) ? fc16 + 1 : fc16;
                fc4  <= (fc4 < 15) ? fc4 + 1 : fc4;
            end
        end
    end

    logic [5:0] cmp_o;
    logic       cmp_st, cmp_fl;
    always @(negedge reloj) begin
        model(cyc, cmp_o, cmp_st, cmp_fl);
        chk("model16", {26'd0, pc_enable, pc_sel, enableIF, resetIF, idex_bubble, stall16, flush16},
            {26'd0, cmp_o, 16'(sc16), 16'(fc16)});
        chk("model4", {50'd0, pc_enable4, pc_sel4, enableIF4, resetIF4, idex_bubble4, stall4, flush4},
            {50'd0, cmp_o, 4'(sc4), 4'(fc4)});
        chk("inv_ifctl", {62'd0, enableIF, resetIF} == 64'd3, 64'd0);
        chk("inv_pcsel", (pc_sel != 2'b00) && !pc_enable, 64'd0);
    end

    task automatic nxt();
        @(posedge reloj);
        #1;
    endtask

    task automatic idle();
        opcode_id = 6'h00; rs_id = 5'd0; rt_id = 5'd0; idex_rt = 5'd0;
        idex_memread = 1'b0; branch_taken_ex = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic set_lu(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] xrt);
        idle();
        opcode_id = op; rs_id = rs; rt_id = rt; idex_rt = xrt; idex_memread = 1'b1;
    endtask

    logic [5:0] ops [8];

    initial begin
        ops[0] = 6'h00; ops[1] = 6'h02; ops[2] = 6'h03; ops[3] = 6'h04;
        ops[4] = 6'h05; ops[5] = 6'h2b; ops[6] = 6'h23; ops[7] = 6'h08;
        resetn = 1'b0;
        idle();
        nxt(); nxt();
        @(negedge reloj);
        chk("in_reset", {pc_enable, enableIF, resetIF, idex_bubble, pc_sel}, 6'b001100);
        nxt();
        resetn = 1'b1;
        @(negedge reloj); chk("hold0", {pc_enable, resetIF}, 2'b01);
        nxt();
        @(negedge reloj); chk("hold1", {pc_enable, resetIF}, 2'b01);
        nxt();
        @(negedge reloj);
        chk("run0", {pc_enable, enableIF, pc_sel, stall16, flush16}, {4'b1100, 32'd0});

        nxt(); set_lu(6'h00, 5'd3, 5'd8, 5'd8);
        @(negedge reloj); chk("lu_stall", {pc_enable, enableIF, idex_bubble}, 3'b001);
        nxt(); idle();
        @(negedge reloj); chk("lu_cnt", stall16, 64'd1);
        nxt(); set_lu(6'h00, 5'd0, 5'd0, 5'd0);
        @(negedge reloj); chk("lu_rt0", {pc_enable, enableIF, idex_bubble}, 3'b110);
        nxt(); set_lu(6'h2b, 5'd2, 5'd9, 5'd9);
        @(negedge reloj); chk("sw_rt", {pc_enable, enableIF, idex_bubble}, 3'b001);
        nxt(); set_lu(6'h23, 5'd2, 5'd9, 5'd9);
        @(negedge reloj); chk("lw_id", {pc_enable, enableIF, idex_bubble, stall16}, {3'b110, 16'd2});

        nxt(); set_lu(6'h02, 5'd5, 5'd0, 5'd5); branch_taken_ex = 1'b1;
        @(negedge reloj);
        chk("br_prio", {pc_sel, resetIF, idex_bubble, enableIF}, 5'b01110);
        nxt(); idle();
        @(negedge reloj); chk("br_cnt", {stall16, flush16}, {16'd2, 16'd1});

        nxt(); idle(); opcode_id = 6'h02; dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge reloj);
            chk("frozen", {pc_enable, enableIF, resetIF, idex_bubble, flush16}, {4'b0000, 16'd1});
            nxt();
        end
        dmem_busy = 1'b0;
        @(negedge reloj); chk("unfreeze_j", {pc_sel, resetIF, pc_enable}, 4'b1011);
        nxt(); idle();
        @(negedge reloj); chk("unfreeze_cnt", flush16, 64'd2);

        nxt(); set_lu(6'h00, 5'd7, 5'd0, 5'd7);
        repeat (20) nxt();
        idle();
        @(negedge reloj); chk("sat4", {stall4, stall16}, {4'd15, 16'd22});

        nxt(); dmem_busy = 1'b1;
        nxt();
        #1 resetn = 1'b0;
        #1 chk("mid_rst", {resetIF, pc_enable, stall16, flush16, stall4, flush4}, {2'b10, 40'd0});
        @(posedge reloj); #1 resetn = 1'b1;
        @(negedge reloj); chk("rehold0", {pc_enable, resetIF}, 2'b01);
        nxt();
        @(negedge reloj); chk("rehold1", {pc_enable, resetIF}, 2'b01);
        nxt(); idle();
        @(negedge reloj); chk("rerun", {pc_enable, enableIF}, 2'b11);

        for (int n = 0; n < 3000; n++) begin
            nxt();
            resetn          = ($urandom_range(0, 299) != 0);
            opcode_id       = ops[$urandom_range(0, 7)];
            rs_id           = 5'($urandom_range(0, 3));
            rt_id           = 5'($urandom_range(0, 3));
            idex_rt         = 5'($urandom_range(0, 3));
            idex_memread    = ($urandom_range(0, 1) == 1);
            branch_taken_ex = ($urandom_range(0, 5) == 0);
            dmem_busy       = ($urandom_range(0, 4) == 0);
        end
        nxt();
        resetn = 1'b1;
        @(negedge reloj);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
